// File: rtl/min_search_seq.sv
// Search-window minimum sequencer: reduces 16-lane SAD beats with a 16-way min tree and
// tracks the global (SAD, {group, lane}) minimum across NUM_GROUPS beats.
module min_search_seq #(
  parameter int ELEMENT_BIT_DEPTH = 14,
  parameter int NUM_GROUPS        = 16,
  localparam int GRP_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [16*ELEMENT_BIT_DEPTH-1:0] sad_array,
  input  logic                            sad_valid,
  output logic                            sad_ready,
  output logic                            busy,
  output logic                            result_valid,
  input  logic                            result_ready,
  output logic [ELEMENT_BIT_DEPTH-1:0]    best_sad,
  output logic [GRP_W+3:0]                best_index
);
  localparam int EBD = ELEMENT_BIT_DEPTH;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  // Handshakes: a beat transfers on a rising edge where sad_valid && sad_ready; the result
  // transfers on a rising edge where result_valid && result_ready. Outputs stay stable while
  // result_valid is high and result_ready is low.

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic             accept;
  logic [GRP_W-1:0] grp;
  logic             s1_valid, s1_first, s1_last;
  logic [EBD-1:0]   s1_min;
  logic [GRP_W+3:0] s1_idx;
  logic             s2_last;
  logic [EBD-1:0]   run_min;
  logic [GRP_W+3:0] run_idx;

  // MIN_16 tree; on equal values the left (lower-lane) operand wins at every level.
  logic [EBD-1:0] l0_v [16];
  logic [3:0]     l0_i [16];
  logic [EBD-1:0] l1_v [8];
  logic [3:0]     l1_i [8];
  logic [EBD-1:0] l2_v [4];
  logic [3:0]     l2_i [4];
  logic [EBD-1:0] l3_v [2];
  logic [3:0]     l3_i [2];
  logic [EBD-1:0] lane_min;
  logic [3:0]     lane_idx;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      l0_v[k] = sad_array[k*EBD +: EBD];
      l0_i[k] = 4'(k);
    end
    for (int k = 0; k < 8; k++) begin
      l1_v[k] = (l0_v[2*k+1] < l0_v[2*k]) ? l0_v[2*k+1] : l0_v[2*k];
      l1_i[k] = (l0_v[2*k+1] < l0_v[2*k]) ? l0_i[2*k+1] : l0_i[2*k];
    end
    for (int k = 0; k < 4; k++) begin
      l2_v[k] = (l1_v[2*k+1] < l1_v[2*k]) ? l1_v[2*k+1] : l1_v[2*k];
      l2_i[k] = (l1_v[2*k+1] < l1_v[2*k]) ? l1_i[2*k+1] : l1_i[2*k];
    end
    for (int k = 0; k < 2; k++) begin
      l3_v[k] = (l2_v[2*k+1] < l2_v[2*k]) ? l2_v[2*k+1] : l2_v[2*k];
      l3_i[k] = (l2_v[2*k+1] < l2_v[2*k]) ? l2_i[2*k+1] : l2_i[2*k];
    end
    lane_min = (l3_v[1] < l3_v[0]) ? l3_v[1] : l3_v[0];
    lane_idx = (l3_v[1] < l3_v[0]) ? l3_i[1] : l3_i[0];
  end

  assign accept = (state == ACCUM) && sad_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && grp == LAST_GRP) state_nxt = DRAIN;
      DRAIN:   if (s2_last) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sad_ready    = (state == ACCUM);
    busy         = (state != IDLE);
    result_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grp      <= '0;
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_min   <= '0;
      s1_idx   <= '0;
      s2_last  <= 1'b0;
      run_min  <= '0;
      run_idx  <= '0;
    end else begin
      if (state == IDLE)  grp <= '0;
      else if (accept)    grp <= grp + 1'b1;
      s1_valid <= accept;
      if (accept) begin
        s1_min   <= lane_min;
        s1_idx   <= {grp, lane_idx};
        s1_first <= (grp == '0);
        s1_last  <= (grp == LAST_GRP);
      end
      // Strict less-than keeps the earliest index on cross-beat ties.
      if (s1_valid && (s1_first || s1_min < run_min)) begin
        run_min <= s1_min;
        run_idx <= s1_idx;
      end
      s2_last <= s1_valid && s1_last;
    end
  end

  assign best_sad   = run_min;
  assign best_index = run_idx;
endmodule

// File: tb/tb_min_search_seq.sv
// Directed bench for min_search_seq: a 4-group and a 1-group instance driven from a vector
// table, plus hand-written reset-abort and idle-input sequences.
module tb_min_search_seq;
  localparam int EBD = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             start4 = 1'b0, valid4 = 1'b0, rr4 = 1'b0;
  logic [16*EBD-1:0] sad4 = '0;
  logic             ready4, busy4, rv4;
  logic [EBD-1:0]   bs4;
  logic [5:0]       bi4;

  logic             start1 = 1'b0, valid1 = 1'b0, rr1 = 1'b0;
  logic [16*EBD-1:0] sad1 = '0;
  logic             ready1, busy1, rv1;
  logic [EBD-1:0]   bs1;
  logic [4:0]       bi1;

  min_search_seq #(.ELEMENT_BIT_DEPTH(EBD), .NUM_GROUPS(4)) u_ng4 (
    .clk(clk), .rst(rst), .start(start4), .sad_array(sad4), .sad_valid(valid4),
    .sad_ready(ready4), .busy(busy4), .result_valid(rv4), .result_ready(rr4),
    .best_sad(bs4), .best_index(bi4)
  );

  min_search_seq #(.ELEMENT_BIT_DEPTH(EBD), .NUM_GROUPS(1)) u_ng1 (
    .clk(clk), .rst(rst), .start(start1), .sad_array(sad1), .sad_valid(valid1),
    .sad_ready(ready1), .busy(busy1), .result_valid(rv1), .result_ready(rr1),
    .best_sad(bs1), .best_index(bi1)
  );

  typedef struct {
    bit ng1;
    int base;
    int step;
    bit p1_en; int p1_g; int p1_l; int p1_v;
    bit p2_en; int p2_g; int p2_l; int p2_v;
    bit gaps;
    bit start_mid;
    int exp_sad;
    int exp_idx;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [16*EBD-1:0] make_beat(input vec_t v, input int g);
    logic [16*EBD-1:0] b;
    int val;
    b = '0;
    for (int k = 0; k < 16; k++) begin
      val = v.base + v.step * (16 * g + k);
      if (v.p1_en && v.p1_g == g && v.p1_l == k) val = v.p1_v;
      if (v.p2_en && v.p2_g == g && v.p2_l == k) val = v.p2_v;
      b[k*EBD +: EBD] = val[EBD-1:0];
    end
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run4(input vec_t v, input int vi);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", vi);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check({tag, "_ready_in_accum"}, 32'(ready4), 1);
    for (int g = 0; g < 4; g++) begin
      if (v.gaps && g > 0) begin
        valid4 = 1'b0;
        sad4   = '0;
        repeat (2) tick();
      end
      valid4 = 1'b1;
      sad4   = make_beat(v, g);
      if (v.start_mid && g == 1) start4 = 1'b1;
      tick();
      start4 = 1'b0;
    end
    valid4 = 1'b0;
    check({tag, "_ready_drop"}, 32'(ready4), 0);
    cyc = 0;
    while (!rv4 && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 2);
    check({tag, "_best_sad"}, 32'(bs4), 32'(v.exp_sad));
    check({tag, "_best_index"}, 32'(bi4), 32'(v.exp_idx));
    if (v.gaps) begin
      valid4 = 1'b1;
      sad4   = '0;
      for (int c = 0; c < 5; c++) begin
        tick();
        check({tag, "_hold_valid"}, 32'(rv4), 1);
        check({tag, "_hold_sad"}, 32'(bs4), 32'(v.exp_sad));
        check({tag, "_hold_index"}, 32'(bi4), 32'(v.exp_idx));
      end
      valid4 = 1'b0;
    end
    rr4    = 1'b1;
    start4 = v.gaps;
    tick();
    rr4    = 1'b0;
    start4 = 1'b0;
    check({tag, "_consumed"}, 32'(rv4), 0);
    check({tag, "_idle"}, 32'(busy4), 0);
    tick();
    check({tag, "_still_idle"}, 32'(busy4), 0);
  endtask

  task automatic run1(input vec_t v, input int vi);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", vi);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    valid1 = 1'b1;
    sad1   = make_beat(v, 0);
    tick();
    valid1 = 1'b0;
    check({tag, "_ready_drop"}, 32'(ready1), 0);
    cyc = 0;
    while (!rv1 && cyc < 10) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 2);
    check({tag, "_best_sad"}, 32'(bs1), 32'(v.exp_sad));
    check({tag, "_best_index"}, 32'(bi1), 32'(v.exp_idx));
    rr1 = 1'b1;
    tick();
    rr1 = 1'b0;
    check({tag, "_consumed"}, 32'(busy1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               ng1 base  step p1 g  l   v      p2 g  l  v  gaps smid sad    idx
    vecs[0] = '{1'b0, 1000,  1, 1'b1, 2, 5, 7,     1'b0, 0, 0, 0, 1'b0, 1'b0, 7,     37};
    vecs[1] = '{1'b0, 500,   0, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0, 1'b0, 500,   0};
    vecs[2] = '{1'b0, 1000,  1, 1'b1, 1, 15, 3,    1'b1, 3, 0, 3, 1'b0, 1'b1, 3,     31};
    vecs[3] = '{1'b0, 1000,  1, 1'b1, 2, 5, 7,     1'b0, 0, 0, 0, 1'b1, 1'b0, 7,     37};
    vecs[4] = '{1'b0, 16383, 0, 1'b1, 3, 15, 16382,1'b0, 0, 0, 0, 1'b0, 1'b0, 16382, 63};
    vecs[5] = '{1'b0, 1000,  1, 1'b1, 0, 0, 6,     1'b1, 1, 0, 5, 1'b0, 1'b0, 5,     16};
    vecs[6] = '{1'b1, 16383, 0, 1'b1, 0, 9, 16382, 1'b0, 0, 0, 0, 1'b0, 1'b0, 16382, 9};
    vecs[7] = '{1'b1, 500,   0, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0, 1'b0, 500,   0};
    vecs[8] = '{1'b1, 16383, 0, 1'b0, 0, 0, 0,     1'b0, 0, 0, 0, 1'b0, 1'b0, 16383, 0};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ready4", 32'(ready4), 0);
    check("rst_busy4", 32'(busy4), 0);
    check("rst_rv4", 32'(rv4), 0);
    check("rst_sad4", 32'(bs4), 0);
    check("rst_idx4", 32'(bi4), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_rv1", 32'(rv1), 0);

    // Beats offered while idle must not start anything.
    valid4 = 1'b1;
    sad4   = '0;
    repeat (3) tick();
    valid4 = 1'b0;
    check("idle_valid_busy", 32'(busy4), 0);
    check("idle_valid_sad", 32'(bs4), 0);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].ng1) run1(vecs[i], i);
      else             run4(vecs[i], i);
    end

    // Abort a search after two accepted beats, then run a fresh one.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int g = 0; g < 2; g++) begin
      valid4 = 1'b1;
      sad4   = make_beat(vecs[5], g);
      tick();
    end
    valid4 = 1'b0;
    tick();
    check("abort_busy_before_rst", 32'(busy4), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(ready4), 0);
    check("abort_busy", 32'(busy4), 0);
    check("abort_rv", 32'(rv4), 0);
    check("abort_sad", 32'(bs4), 0);
    check("abort_idx", 32'(bi4), 0);
    repeat (4) tick();
    check("abort_no_result", 32'(rv4), 0);
    run4(vecs[0], 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
